// File: rtl/mat_pkg.sv
// Shared definitions for the matrix datapath: sizing helpers and loader states.
package mat_pkg;

    // Ceiling log2 with a floor of 1, so even a single-entry counter has a bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result < 1) result = 1;
        return result;
    endfunction

    // Number of elements in a rows x cols matrix.
    function automatic int mat_size(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Loader frame states: collecting A, collecting B, publishing.
    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_PUB = 2'd2
    } state_t;

endpackage

// File: rtl/mat_fill.sv
// Working register for one matrix: element index counter plus flat storage.
module mat_fill
    import mat_pkg::*;
#(
    parameter int ELEMS = 6,
    parameter int BIT   = 1,
    parameter int CNT_W = clog2(ELEMS)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  write,
    input  logic [BIT-1:0]        data,
    output logic                  done,
    output logic [ELEMS*BIT-1:0]  flat
);

    logic [CNT_W-1:0] cnt;

    // The element currently addressed is the last one of the matrix.
    assign done = (cnt == CNT_W'(ELEMS - 1));

    // Store each written element at the counter position; clear discards the frame.
    // NOTE: flat is a small flop array, not a RAM, so it takes the reset like
    // any other register; use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            flat <= '0;
        end else if (clear) begin
            cnt  <= '0;
            flat <= '0;
        end else if (write) begin
            for (int e = 0; e < ELEMS; e++) begin
                if (cnt == CNT_W'(e)) flat[e*BIT +: BIT] <= data;
            end
            cnt <= done ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mat_loader.sv
// Frames A then B element streams into flat vectors and publishes them with a strobe.
module mat_loader
    import mat_pkg::*;
#(
    parameter int Bit = 1,
    parameter int N   = 2,
    parameter int M   = 3,
    parameter int P   = 3
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Bit-1:0]       in_data,
    input  logic                 in_last,
    output logic [Bit*N*M-1:0]   matriz_A,
    output logic [Bit*M*P-1:0]   matriz_B,
    output logic                 load_en,
    output logic                 frame_err
);

    localparam int NM    = mat_size(N, M);
    localparam int MP    = mat_size(M, P);
    localparam int CNT_W = clog2((NM > MP) ? NM : MP);

    state_t             state;
    logic               xfer;
    logic               a_write;
    logic               b_write;
    logic               fill_clear;
    logic               bad_beat;
    logic               publish;
    logic               a_done;
    logic               b_done;
    logic [Bit*NM-1:0]  a_flat;
    logic [Bit*MP-1:0]  b_flat;
    logic [Bit*MP-1:0]  b_merged;

    assign xfer = in_valid && in_ready;

    mat_fill #(.ELEMS(NM), .BIT(Bit), .CNT_W(CNT_W)) u_fill_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fill_clear),
        .write (a_write),
        .data  (in_data),
        .done  (a_done),
        .flat  (a_flat)
    );

    mat_fill #(.ELEMS(MP), .BIT(Bit), .CNT_W(CNT_W)) u_fill_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fill_clear),
        .write (b_write),
        .data  (in_data),
        .done  (b_done),
        .flat  (b_flat)
    );

    // Decode the current beat into fill writes, frame discard and publish.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        a_write    = 1'b0;
        b_write    = 1'b0;
        fill_clear = 1'b0;
        bad_beat   = 1'b0;
        publish    = 1'b0;
        if (flush) begin
            fill_clear = 1'b1;
        end else begin
            case (state)
                S_A: if (xfer) begin
                    if (in_last) begin
                        bad_beat   = 1'b1;
                        fill_clear = 1'b1;
                    end else begin
                        a_write = 1'b1;
                    end
                end
                S_B: if (xfer) begin
                    if (in_last != b_done) begin
                        bad_beat   = 1'b1;
                        fill_clear = 1'b1;
                    end else if (b_done) begin
                        publish    = 1'b1;
                        fill_clear = 1'b1;
                    end else begin
                        b_write = 1'b1;
                    end
                end
                default: fill_clear = 1'b1;
            endcase
        end
    end

    // Final B element is taken straight from the bus so it publishes on its own edge.
    always_comb begin
        b_merged = b_flat;
        b_merged[(MP-1)*Bit +: Bit] = in_data;
    end

    // Frame FSM with registered ready, strobes and published vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            in_ready  <= 1'b0;
            load_en   <= 1'b0;
            frame_err <= 1'b0;
            matriz_A  <= '0;
            matriz_B  <= '0;
        end else begin
            in_ready  <= 1'b1;
            load_en   <= 1'b0;
            frame_err <= bad_beat;
            if (flush || bad_beat) begin
                state <= S_A;
            end else begin
                case (state)
                    S_A:   if (a_write && a_done) state <= S_B;
                    S_B:   if (publish) begin
                        matriz_A <= a_flat;
                        matriz_B <= b_merged;
                        load_en  <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= S_PUB;
                    end
                    default: state <= S_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mat_loader.sv
// Self-checking bench for mat_loader (Bit=1, N=2, M=3, P=3) with a frame scoreboard.
module tb_mat_loader;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [0:0] in_data;
    logic       in_last;
    logic [5:0] matriz_A;
    logic [8:0] matriz_B;
    logic       load_en;
    logic       frame_err;

    typedef struct {
        logic [5:0] a;
        logic [8:0] b;
    } frame_t;

    frame_t     sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         load_seen = 0;
    int         err_seen = 0;
    int         exp_loads = 0;
    int         exp_errs = 0;
    logic [5:0] held_a = '0;
    logic [8:0] held_b = '0;

    mat_loader #(.Bit(1), .N(2), .M(3), .P(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .matriz_A  (matriz_A),
        .matriz_B  (matriz_B),
        .load_en   (load_en),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each strobe and checks outputs hold otherwise.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_a = '0;
                held_b = '0;
            end else begin
                if (load_en) begin
                    load_seen++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_load", 32'd1, 32'd0);
                    end else begin
                        f = sb_q.pop_front();
                        check("pub_A", matriz_A, f.a);
                        check("pub_B", matriz_B, f.b);
                    end
                    held_a = matriz_A;
                    held_b = matriz_B;
                end else begin
                    check("hold_A", matriz_A, held_a);
                    check("hold_B", matriz_B, held_b);
                end
                if (frame_err) err_seen++;
            end
        end
    end

    // Drive one beat and return #1 after the edge on which it transferred.
    task automatic send_beat(input logic d, input logic last, input bit gaps);
        int budget;
        if (gaps) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 2) != 0) break;
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 50) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_err_pulse(input string tag);
        check({tag, "_err_hi"}, {31'd0, frame_err}, 32'd1);
        check({tag, "_no_load"}, {31'd0, load_en}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_err_lo"}, {31'd0, frame_err}, 32'd0);
        exp_errs++;
    endtask

    // mode 0: clean frame, 1: in_last on A element index 2, 2: final B without in_last.
    task automatic send_frame(input logic [5:0] a, input logic [8:0] b, input bit gaps, input int mode);
        frame_t f;
        logic   last;
        for (int e = 0; e < 6; e++) begin
            if (mode == 1 && e == 2) begin
                send_beat(a[e], 1'b1, gaps);
                expect_err_pulse("early_last");
                return;
            end
            send_beat(a[e], 1'b0, gaps);
        end
        for (int e = 0; e < 9; e++) begin
            last = (e == 8) && (mode != 2);
            if (e == 8 && mode == 0) begin
                f.a = a;
                f.b = b;
                sb_q.push_back(f);
            end
            send_beat(b[e], last, gaps);
        end
        if (mode == 2) begin
            expect_err_pulse("missing_last");
        end else begin
            check("load_en_after_final", {31'd0, load_en}, 32'd1);
            check("ready_low_in_pub", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            check("load_en_one_cycle", {31'd0, load_en}, 32'd0);
            check("ready_back", {31'd0, in_ready}, 32'd1);
            exp_loads++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        // Reset state.
        #12;
        check("rst_A", matriz_A, 6'd0);
        check("rst_B", matriz_B, 9'd0);
        check("rst_load_en", {31'd0, load_en}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {31'd0, in_ready}, 32'd1);

        // Clean frame, in_valid held high.
        send_frame(6'b110101, 9'b100010001, 1'b0, 0);
        check("clean_A", matriz_A, 6'b110101);
        check("clean_B", matriz_B, 9'b100010001);

        // Different data back to back, then the same frame with random gaps.
        send_frame(6'b001010, 9'b011101110, 1'b0, 0);
        send_frame(6'b110101, 9'b100010001, 1'b1, 0);
        send_frame(6'b011011, 9'b110001101, 1'b1, 0);

        // Early in_last, then a clean frame.
        send_frame(6'b111111, 9'b111111111, 1'b0, 1);
        send_frame(6'b011010, 9'b011101110, 1'b0, 0);

        // Missing in_last on the final B element.
        send_frame(6'b100100, 9'b000000111, 1'b0, 2);
        check("missing_hold_A", matriz_A, 6'b011010);

        // Flush after B element 4, with a beat offered on the flush edge.
        for (int e = 0; e < 6; e++) send_beat(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 5; e++) send_beat(1'b1, 1'b0, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_no_err", {31'd0, frame_err}, 32'd0);
        check("flush_no_load", {31'd0, load_en}, 32'd0);
        send_frame(6'b101001, 9'b010110011, 1'b0, 0);

        // Reset during S_B.
        for (int e = 0; e < 6; e++) send_beat(1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) send_beat(1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_A", matriz_A, 6'd0);
        check("midrst_B", matriz_B, 9'd0);
        check("midrst_load_en", {31'd0, load_en}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_ready_held", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_pre_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("midrst_ready_post_edge", {31'd0, in_ready}, 32'd1);
        send_frame(6'b010011, 9'b101000110, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("load_count", load_seen, exp_loads);
        check("err_count", err_seen, exp_errs);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mat_loader.md
Name: mat_loader

Overview:
- Upstream feeder for the matrix multiplier.
- Accepts matrix elements one per beat over a valid/ready stream: A first, then B, each row-major.
- Assembles them into flat vectors and publishes both vectors together with a one-cycle load strobe.
- The strobe drives the multiplier's clk_enable; published vectors stay stable until the next complete, error-free frame.

Parameters:
- Bit, 1, width in bits of one matrix element
- N, 2, rows of A
- M, 3, columns of A / rows of B
- P, 3, columns of B

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of the frame in progress
- in_valid  input  1  element beat valid
- in_ready  output  1  loader can accept a beat
- in_data  input  Bit  element value
- in_last  input  1  marks the final element of B (end of frame)
- matriz_A  output  Bit*N*M  published A; element e = i*M+k at bits [e*Bit +: Bit]
- matriz_B  output  Bit*M*P  published B; element e = k*P+j at bits [e*Bit +: Bit]
- load_en  output  1  one-cycle strobe; matriz_A/B are valid and new while high
- frame_err  output  1  one-cycle pulse when a framing error discards a frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: matriz_A = 0, matriz_B = 0, load_en = 0, frame_err = 0, in_ready = 0, state = S_A, counter = 0, working registers = 0.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts.
- Transfer: a beat transfers on any edge where in_valid && in_ready. No beat transfers otherwise, and in_data/in_last are ignored.
- State S_A:
  - in_ready = 1.
  - Each transfer writes in_data to working-A element cnt, then cnt increments.
  - After element N*M-1: cnt = 0, go to S_B.
- State S_B:
  - in_ready = 1.
  - Each transfer writes working-B element cnt.
  - Non-final element (cnt < M*P-1) with in_last = 0: cnt increments.
  - Final element (cnt = M*P-1) with in_last = 1:
    - At that same edge, matriz_A <= working A and matriz_B <= working B with the final element merged in.
    - load_en <= 1; state <= S_PUB.
- State S_PUB (exactly one cycle):
  - load_en = 1, in_ready = 0.
  - Next edge: load_en <= 0, in_ready <= 1, cnt = 0, state = S_A.
- Latency and throughput:
  - load_en is high during the cycle immediately after the final beat's edge.
  - Maximum throughput is one frame per N*M + M*P + 1 cycles.
- Framing errors:
  - Triggered by in_last = 1 on any beat other than the final B element, or in_last = 0 on the final B element.
  - Response: frame_err pulses for 1 cycle (registered, high the cycle after the offending edge).
  - State goes to S_A with cnt = 0. Working registers are discarded.
  - matriz_A/B are unchanged and no load_en is issued.
  - in_ready stays 1, so the next frame may start the following cycle.
- flush:
  - Synchronous; overrides any transfer on the same edge.
  - Effect: state = S_A, cnt = 0, working registers discarded.
  - No load_en, no frame_err, and matriz_A/B are unchanged.
  - flush in S_PUB does not cancel that cycle's load_en, which is already registered. The return to S_A proceeds normally.
- Reset mid-frame: all state is lost immediately (asynchronous), and outputs take their reset values.
- Widths:
  - cnt width = clog2(max(N*M, M*P)), minimum 1.
  - No arithmetic on data; elements are stored verbatim.
- Output ordering: matriz_A/B never change except on the edge that raises load_en, or on reset.

Decomposition:
- Shared package mat_pkg holds:
  - a clog2 constant function;
  - the state encoding (S_A, S_B, S_PUB);
  - a size helper (element count from rows and columns), also used by the multiplier and the downstream collector.
- One natural sub-module, mat_fill:
  - Parameterised by element count and Bit.
  - Contains the element index counter plus the working flat register, with write/clear/done.
  - Instantiated twice (A and B).
  - The FSM, framing check and publish registers stay in mat_loader.

Test Plan (Bit=1, N=2, M=3, P=3):
- Clean frame:
  - Stimulus: A = 1,0,1,0,1,1; B = 1,0,0,0,1,0,0,0,1 with in_last on the 9th B beat; in_valid held high.
  - Response: matriz_A = 6'b110101, matriz_B = 9'b100010001, load_en high exactly 1 cycle (the cycle after beat 15), in_ready low that cycle, next frame accepted the cycle after.
- Backpressure/gaps:
  - Stimulus: same frame with in_valid deasserted on random cycles.
  - Response: identical outputs. load_en occurs 1 cycle after the final transfer. Outputs are unchanged before that.
- Early in_last:
  - Stimulus: in_last = 1 on A element 3.
  - Response: frame_err single pulse, no load_en, matriz_A/B hold their previous values. A following clean frame publishes correctly.
- Missing in_last:
  - Stimulus: final B beat sent with in_last = 0.
  - Response: frame_err pulse, no load_en, outputs unchanged.
- flush mid-B:
  - Stimulus: assert flush after B element 4, then send a fresh full frame.
  - Response: no load_en or frame_err from the aborted frame. The fresh frame publishes its own values only.
- Reset mid-frame:
  - Stimulus: drop rst_n asynchronously during S_B.
  - Response: matriz_A/B = 0 and load_en = 0 immediately, in_ready = 0 while rst_n is low and rises 1 edge after release. A full frame then loads correctly.
